muldiv_seq: RTL and testbench

//   Iterative RV32M multiply/divide sequencer for the execute stage.

---
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_seq.sv | 145 ++++++++++++++
 tb/tb_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the iterative RV32M multiply/divide sequencer.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, funct, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, one bit per cycle.
// Operates on magnitudes and applies the sign in a single fix-up cycle.
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sa_neg, sb_neg, is_div;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct_q  <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opd_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        funct_d  = funct_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        is_div = bus.funct[2];
        // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
        sa_neg = bus.rs1[XLEN-1] && ((bus.funct == 3'b001) || (bus.funct == 3'b010) ||
                                     (bus.funct == 3'b100) || (bus.funct == 3'b110));
        sb_neg = bus.rs2[XLEN-1] && ((bus.funct == 3'b001) || (bus.funct == 3'b100) ||
                                     (bus.funct == 3'b110));
        abs_a  = sa_neg ? -bus.rs1 : bus.rs1;
        abs_b  = sb_neg ? -bus.rs2 : bus.rs2;

        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_sh = {rem_q, acc_q[XLEN-1]};
        diff   = rem_sh - {1'b0, opd_q};

        // High half of a signed product needs the full-width negation, not just the half
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -rem_q : rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    funct_d = bus.funct;
                    if (is_div && (bus.rs2 == '0)) begin
                        result_d = bus.funct[1] ? bus.rs1 : '1;
                        state_d  = S_DONE;
                    end else if (is_div && !bus.funct[0] && (bus.rs1 == MIN_VAL) && (bus.rs2 == '1)) begin
                        result_d = bus.funct[1] ? '0 : MIN_VAL;
                        state_d  = S_DONE;
                    end else begin
                        neg_d   = (is_div && bus.funct[1]) ? sa_neg : (sa_neg ^ sb_neg);
                        cnt_d   = CW'(XLEN - 1);
                        acc_d   = is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        opd_d   = is_div ? abs_b : abs_a;
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!funct_q[2]) begin
                        acc_d = {sum, acc_q[XLEN-1:1]};
                    end else if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    unique case (funct_q)
                        3'b000:                 result_d = prod[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quo;
                        default:                result_d = rem;
                    endcase
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.flush || bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M cases, flush/reset aborts, then random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();
    muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MIN_VAL && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: a transfer happens when out_valid and out_ready meet without flush
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%08h expected none", bus.result);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                chk(mon_name, bus.result, mon_exp);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name);
        @(posedge clk); #1;
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.funct    = f;
        bus.rs1      = a;
        bus.rs2      = b;
        if (push) begin
            exp_q.push_back(ref_model(f, a, b));
            name_q.push_back(name);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.funct    = 3'($urandom);
        bus.rs1      = $urandom;
        bus.rs2      = $urandom;
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string name);
        int          n;
        logic [31:0] e;
        e = ref_model(f, a, b);
        issue(f, a, b, 1'b1, name);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid within 200 cycles", name);
            exp_q.delete();
            name_q.delete();
            return;
        end
        chk({name, "_latency"}, 32'(n + 1), is_special(f, a, b) ? 32'd1 : 32'(XLEN + 2));
        for (int i = 0; i < hold; i++) begin
            chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_hold_result"}, bus.result, e);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        chk({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_VAL;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.funct     = 3'd0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
        do_op(3'd1, MIN_VAL, MIN_VAL, 0, "mulh");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
        do_op(3'd5, 32'd100, 32'd7, 0, "divu");
        do_op(3'd7, 32'd100, 32'd7, 0, "remu");
        do_op(3'd5, 32'd5, 32'd0, 0, "divu_by0");
        do_op(3'd7, 32'd5, 32'd0, 0, "remu_by0");
        do_op(3'd4, MIN_VAL, 32'hFFFF_FFFF, 0, "div_ovf");
        do_op(3'd6, MIN_VAL, 32'hFFFF_FFFF, 0, "rem_ovf");
        do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, "backpressure");

        // Flush in CALC
        issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, "flush_calc");
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk("flush_no_valid", 32'(seen), 32'd0);
        do_op(3'd6, 32'hFFFF_FF00, 32'd7, 0, "after_flush");

        // Flush together with a request in IDLE: not accepted
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.funct    = 3'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush wins over out_ready in DONE
        issue(3'd5, 32'd9, 32'd0, 1'b0, "flush_done");
        chk("flush_done_valid", 32'(bus.out_valid), 32'd1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-CALC
        issue(3'd4, 32'h7654_3210, 32'd13, 1'b0, "reset_calc");
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(3'd2, 32'hFFFF_FFF0, 32'd3, 0, "after_reset");

        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom), pick(), pick(), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
